wm_phase_sequencer: RTL and testbench

WM_PHASE_SEQUENCER -- requirements
Module: wm_phase_sequencer

---
 rtl/wm_pkg.sv | 61 ++++++
 rtl/wm_tach_watchdog.sv | 52 +++++
 rtl/wm_phase_sequencer.sv | 148 ++++++++++++++
 tb/tb_wm_phase_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - phase codes, actuator bundle and phase lookups for the washer sequencer
package wm_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_READY = 3'd1,
        PH_SOAK  = 3'd2,
        PH_WASH  = 3'd3,
        PH_RINSE = 3'd4,
        PH_SPIN  = 3'd5
    } phase_e;

    typedef struct packed {
        logic lid_lock;
        logic water_valve;
        logic motor_on;
        logic motor_fast;
        logic drain_pump;
    } act_t;

    function automatic logic is_timed(input logic [2:0] ph);
        return (ph >= PH_SOAK) && (ph <= PH_SPIN);
    endfunction

    function automatic int unsigned phase_cycles(input logic [2:0] ph,
                                                 input int unsigned soak,
                                                 input int unsigned wash,
                                                 input int unsigned rinse,
                                                 input int unsigned spin);
        case (ph)
            PH_SOAK:  return soak;
            PH_WASH:  return wash;
            PH_RINSE: return rinse;
            PH_SPIN:  return spin;
            default:  return 0;
        endcase
    endfunction

    // Reserved codes fall through to lid-locked, everything else off.
    function automatic act_t decode_actuators(input logic [2:0] ph);
        act_t a;
        a = '0;
        a.lid_lock = (ph != PH_IDLE);
        case (ph)
            PH_SOAK:  a.water_valve = 1'b1;
            PH_WASH:  a.motor_on = 1'b1;
            PH_RINSE: begin
                a.water_valve = 1'b1;
                a.motor_on    = 1'b1;
            end
            PH_SPIN:  begin
                a.motor_on   = 1'b1;
                a.motor_fast = 1'b1;
                a.drain_pump = 1'b1;
            end
            default: ;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/wm_tach_watchdog.sv
// rtl/wm_tach_watchdog.sv - flags a motor failure when tach pulses stop while the motor runs
module wm_tach_watchdog
#(
    parameter int unsigned TACH_TIMEOUT = 8
)
(
    input  logic clock,
    input  logic reset,
    input  logic i_motor_on,
    input  logic i_tach,
    input  logic i_idle,
    output logic o_fail
);

    localparam int TW = $clog2(TACH_TIMEOUT) + 1;

    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_next;
    logic          r_tach_prev;
    logic          r_fail;
    logic          w_rise;

    // Saturates at the timeout so a stalled motor never wraps back to a "healthy" count.
    always_comb begin
        w_rise     = i_tach & ~r_tach_prev;
        w_cnt_next = r_cnt;
        if (!i_motor_on || w_rise) begin
            w_cnt_next = '0;
        end else if (r_cnt != TW'(TACH_TIMEOUT)) begin
            w_cnt_next = r_cnt + TW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_tach_prev <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_tach_prev <= i_tach;
            if (i_idle) begin
                r_fail <= 1'b0;
            end else if (w_cnt_next == TW'(TACH_TIMEOUT)) begin
                r_fail <= 1'b1;
            end
        end
    end

    assign o_fail = r_fail;

endmodule

// File: rtl/wm_phase_sequencer.sv
// rtl/wm_phase_sequencer.sv - washer phase timer, actuator decode, tach watchdog
// Optional vibration balance detector enabled by WM_BALANCE_DET_EN.
module wm_phase_sequencer
    import wm_pkg::*;
#(
    parameter int unsigned SOAK_CYCLES  = 16,
    parameter int unsigned WASH_CYCLES  = 32,
    parameter int unsigned RINSE_CYCLES = 24,
    parameter int unsigned SPIN_CYCLES  = 40,
    parameter int unsigned TACH_TIMEOUT = 8,
    parameter int unsigned VIB_LIMIT    = 4,
    parameter int unsigned VIB_WINDOW   = 16
)
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] state,
    input  logic       tach,
    input  logic       vib,
    output logic       sig_Time_Out,
    output logic       sig_Out_Of_Balance,
    output logic       sig_Motor_Failure,
    output logic       lid_lock,
    output logic       water_valve,
    output logic       motor_on,
    output logic       motor_fast,
    output logic       drain_pump
);

    localparam int unsigned MAX_SW  = (SOAK_CYCLES > WASH_CYCLES) ? SOAK_CYCLES : WASH_CYCLES;
    localparam int unsigned MAX_RS  = (RINSE_CYCLES > SPIN_CYCLES) ? RINSE_CYCLES : SPIN_CYCLES;
    localparam int unsigned MAX_DUR = (MAX_SW > MAX_RS) ? MAX_SW : MAX_RS;
    localparam int          CW      = $clog2(MAX_DUR - 1) + 1;

    logic [2:0]    r_state_q;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_load;
    logic          r_done;
    logic          r_tout;
    act_t          r_act;
    logic          w_change;
    logic          w_timed;
    logic          w_idle;
    int unsigned   w_dur;

    always_comb begin
        w_change = (state != r_state_q);
        w_timed  = is_timed(state);
        w_dur    = phase_cycles(state, SOAK_CYCLES, WASH_CYCLES, RINSE_CYCLES, SPIN_CYCLES);
        w_load   = CW'(w_dur - 1);
        w_idle   = (r_state_q == PH_IDLE);
    end

    // A phase change outranks an expiry landing on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q <= PH_IDLE;
            r_cnt     <= '0;
            r_done    <= 1'b1;
            r_tout    <= 1'b0;
            r_act     <= '0;
        end else begin
            r_state_q <= state;
            r_tout    <= 1'b0;
            r_act     <= decode_actuators(r_state_q);
            if (w_change) begin
                r_cnt  <= w_timed ? w_load : '0;
                r_done <= ~w_timed;
            end else if (!r_done) begin
                if (r_cnt == '0) begin
                    r_done <= 1'b1;
                    r_tout <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end
    end

    wm_tach_watchdog #(
        .TACH_TIMEOUT(TACH_TIMEOUT)
    ) u_tach_wd (
        .clock      (clock),
        .reset      (reset),
        .i_motor_on (r_act.motor_on),
        .i_tach     (tach),
        .i_idle     (w_idle),
        .o_fail     (sig_Motor_Failure)
    );

`ifdef WM_BALANCE_DET_EN
    localparam int WW  = $clog2(VIB_WINDOW - 1) + 1;
    localparam int VCW = $clog2(VIB_LIMIT) + 1;

    logic [WW-1:0]  r_win;
    logic [VCW-1:0] r_vib_cnt;
    logic [VCW-1:0] w_vib_base;
    logic [VCW-1:0] w_vib_next;
    logic           r_vib_prev;
    logic           r_oob;
    logic           w_vib_rise;
    logic           w_in_spin;

    always_comb begin
        w_in_spin  = (r_state_q == PH_SPIN);
        w_vib_rise = vib & ~r_vib_prev;
        w_vib_base = (r_win == '0) ? '0 : r_vib_cnt;
        w_vib_next = (w_vib_base >= VCW'(VIB_LIMIT)) ? w_vib_base : w_vib_base + VCW'(w_vib_rise);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_win      <= '0;
            r_vib_cnt  <= '0;
            r_vib_prev <= 1'b0;
            r_oob      <= 1'b0;
        end else begin
            r_vib_prev <= vib;
            if (!w_in_spin) begin
                r_win     <= '0;
                r_vib_cnt <= '0;
                r_oob     <= 1'b0;
            end else begin
                r_win     <= (r_win == WW'(VIB_WINDOW - 1)) ? '0 : r_win + WW'(1);
                r_vib_cnt <= w_vib_next;
                if (w_vib_next >= VCW'(VIB_LIMIT)) begin
                    r_oob <= 1'b1;
                end
            end
        end
    end

    assign sig_Out_Of_Balance = r_oob;
`else
    localparam int unsigned unused_vib_cfg = VIB_LIMIT + VIB_WINDOW;
    logic w_unused_vib;
    assign w_unused_vib       = vib;
    assign sig_Out_Of_Balance = 1'b0;
`endif

    assign sig_Time_Out = r_tout;
    assign lid_lock     = r_act.lid_lock;
    assign water_valve  = r_act.water_valve;
    assign motor_on     = r_act.motor_on;
    assign motor_fast   = r_act.motor_fast;
    assign drain_pump   = r_act.drain_pump;

endmodule

// File: tb/tb_wm_phase_sequencer.sv
// tb/tb_wm_phase_sequencer.sv - directed and randomized checks of wm_phase_sequencer against a reference model
module tb_wm_phase_sequencer;

    localparam int SOAK = 4, WASH = 8, RINSE = 12, SPIN = 6;
    localparam int TT = 8, VL = 4, VW = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] state = 3'd0;
    logic       tach  = 1'b0;
    logic       vib   = 1'b0;
    logic       sig_Time_Out, sig_Out_Of_Balance, sig_Motor_Failure;
    logic       lid_lock, water_valve, motor_on, motor_fast, drain_pump;

    wm_phase_sequencer #(
        .SOAK_CYCLES(SOAK), .WASH_CYCLES(WASH), .RINSE_CYCLES(RINSE), .SPIN_CYCLES(SPIN),
        .TACH_TIMEOUT(TT), .VIB_LIMIT(VL), .VIB_WINDOW(VW)
    ) dut (
        .clock(clock), .reset(reset), .state(state), .tach(tach), .vib(vib),
        .sig_Time_Out(sig_Time_Out), .sig_Out_Of_Balance(sig_Out_Of_Balance),
        .sig_Motor_Failure(sig_Motor_Failure), .lid_lock(lid_lock),
        .water_valve(water_valve), .motor_on(motor_on), .motor_fast(motor_fast),
        .drain_pump(drain_pump)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: absolute-edge deadlines instead of a down-counter.
    int         m_n, m_deadline, m_last_ref, m_spin_edges, m_vcnt;
    logic [2:0] m_sq;
    logic [4:0] m_act;
    logic       m_tout, m_oob, m_fail, m_tach_prev, m_vib_prev;

    function automatic logic [4:0] act_of(input logic [2:0] s);
        case (s)
            3'd0:    return 5'b00000;
            3'd1:    return 5'b10000;
            3'd2:    return 5'b11000;
            3'd3:    return 5'b10100;
            3'd4:    return 5'b11100;
            3'd5:    return 5'b10111;
            default: return 5'b10000;
        endcase
    endfunction

    function automatic int dur_of(input logic [2:0] s);
        case (s)
            3'd2:    return SOAK;
            3'd3:    return WASH;
            3'd4:    return RINSE;
            3'd5:    return SPIN;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] observed();
        return {sig_Time_Out, sig_Out_Of_Balance, sig_Motor_Failure,
                lid_lock, water_valve, motor_on, motor_fast, drain_pump};
    endfunction

    task automatic model_reset();
        m_n = 0; m_deadline = -1; m_last_ref = 0; m_spin_edges = 0; m_vcnt = 0;
        m_sq = 3'd0; m_act = 5'b0; m_tout = 0; m_oob = 0; m_fail = 0;
        m_tach_prev = 0; m_vib_prev = 0;
    endtask

    task automatic model_edge();
        logic rise_t, rise_v;
        int   d;
        m_n++;
        rise_t = tach && !m_tach_prev;
        rise_v = vib && !m_vib_prev;
        if (!m_act[2] || rise_t) m_last_ref = m_n;
        if (m_sq == 3'd0) m_fail = 0;
        else if (m_act[2] && (m_n - m_last_ref) >= TT) m_fail = 1;
`ifdef WM_BALANCE_DET_EN
        if (m_sq == 3'd5) begin
            if (m_spin_edges % VW == 0) m_vcnt = 0;
            m_vcnt += int'(rise_v);
            if (m_vcnt >= VL) m_oob = 1;
            m_spin_edges++;
        end else begin
            m_spin_edges = 0; m_vcnt = 0; m_oob = 0;
        end
`else
        m_oob = 0;
`endif
        d = dur_of(state);
        if (state != m_sq) begin
            m_tout = 0;
            m_deadline = (d > 0) ? m_n + d : -1;
        end else begin
            m_tout = (m_n == m_deadline);
        end
        m_act = act_of(m_sq);
        m_sq = state; m_tach_prev = tach; m_vib_prev = vib;
    endtask

    task automatic check(input string tag);
        logic [7:0] obs, exp;
        obs = observed();
        exp = {m_tout, m_oob, m_fail, m_act};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, m_n, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] s, input logic t, input logic v, input string tag);
        state = s; tach = t; vib = v;
        @(posedge clock);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        expect_val({tag, "_async"}, int'(observed()), 0);
        @(posedge clock);
        #1;
        expect_val({tag, "_held"}, int'(observed()), 0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int pc, pidx, fidx, seg_len, trate;
        logic [2:0] s;
        logic t;

        model_reset();
        do_reset("reset");
        for (int i = 0; i < 3; i++) step(3'd0, 1'b0, 1'b0, "idle");

        // WASH held with no tach: one pulse, then silence; tach loss raises failure.
        pc = 0; pidx = 0; fidx = 0;
        for (int i = 1; i <= 30; i++) begin
            step(3'd3, 1'b0, 1'b0, "wash_hold");
            if (sig_Time_Out) begin pc++; pidx = i; end
            if (sig_Motor_Failure && fidx == 0) fidx = i;
        end
        expect_val("wash_pulse_count", pc, 1);
        expect_val("wash_pulse_edge", pidx, 9);
        expect_val("tach_fail_edge", fidx, 10);
        step(3'd0, 1'b0, 1'b0, "to_idle");
        expect_val("fail_held_until_idle", int'(sig_Motor_Failure), 1);
        step(3'd0, 1'b0, 1'b0, "idle");
        expect_val("fail_cleared_in_idle", int'(sig_Motor_Failure), 0);

        // SOAK -> WASH exactly on the SOAK expiry edge.
        pc = 0; pidx = 0;
        for (int i = 1; i <= 24; i++) begin
            step((i <= 4) ? 3'd2 : 3'd3, 1'(i % 2), 1'b0, "soak_to_wash");
            if (sig_Time_Out) begin pc++; pidx = i; end
        end
        expect_val("collide_pulse_count", pc, 1);
        expect_val("collide_pulse_edge", pidx, 13);
        step(3'd0, 1'b0, 1'b0, "idle");
        step(3'd0, 1'b0, 1'b0, "idle");

        // Reset mid-RINSE, then RINSE is timed afresh.
        step(3'd4, 1'b1, 1'b0, "rinse");
        step(3'd4, 1'b0, 1'b0, "rinse");
        do_reset("reset_mid_rinse");
        pc = 0; pidx = 0;
        for (int i = 1; i <= 16; i++) begin
            step(3'd4, 1'(i % 2), 1'b0, "rinse_fresh");
            if (sig_Time_Out) begin pc++; pidx = i; end
        end
        expect_val("rinse_pulse_count", pc, 1);
        expect_val("rinse_pulse_edge", pidx, 13);

        // Actuator sweep over every code, including the reserved ones.
        for (int c = 0; c < 8; c++) begin
            step(3'(c), 1'b1, 1'b0, "sweep");
            step(3'(c), 1'b0, 1'b0, "sweep");
            expect_val($sformatf("act_code%0d", c),
                       int'({lid_lock, water_valve, motor_on, motor_fast, drain_pump}),
                       int'(act_of(3'(c))));
            step(3'(c), 1'b1, 1'b0, "sweep");
        end
        step(3'd0, 1'b0, 1'b0, "idle");

        // Vibration burst during SPIN.
        for (int i = 1; i <= 12; i++) step(3'd5, 1'(i % 2), (i <= 10) ? 1'(i % 2) : 1'b0, "spin_vib");
`ifdef WM_BALANCE_DET_EN
        expect_val("oob_in_spin", int'(sig_Out_Of_Balance), 1);
`else
        expect_val("oob_in_spin", int'(sig_Out_Of_Balance), 0);
`endif
        step(3'd0, 1'b0, 1'b0, "idle");
        step(3'd0, 1'b0, 1'b0, "idle");
        expect_val("oob_after_idle", int'(sig_Out_Of_Balance), 0);

        // Randomized phases, tach rates, vibration and occasional resets.
        for (int seg = 0; seg < 40; seg++) begin
            s = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 5));
            seg_len = int'($urandom_range(1, 14));
            trate = int'($urandom_range(0, 2));
            for (int j = 0; j < seg_len; j++) begin
                t = (trate == 0) ? 1'b0 : ($urandom_range(0, trate) == 0);
                step(s, t, 1'($urandom_range(0, 1)), "random");
            end
            if ($urandom_range(0, 9) == 0) do_reset("reset_random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
